bram_stream_reader: RTL

//  Read-side initiator for one BRAM port (single-port or either dual-port side).
//  On a start pulse it issues a burst of sequential reads and returns the words
//  as a valid/ready stream. It absorbs the 1-cycle BRAM read latency and

---
 rtl/bram_stream_reader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/bram_stream_reader.sv
// Burst read initiator for one BRAM port. It returns the words as a valid/ready
// stream, using a 3-entry FIFO to absorb read latency and consumer stalls.
module bram_stream_reader #(
    parameter int WIDTH = 128,
    parameter int ADDR  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADDR-1:0]  base,
    input  logic [ADDR:0]    len,
    output logic             busy,
    output logic             done,
    output logic             mem_en,
    output logic             mem_we,
    output logic [ADDR-1:0]  mem_addr,
    input  logic [WIDTH-1:0] mem_dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       state;
    logic [ADDR-1:0]  base_r;
    logic [ADDR:0]    len_r;
    logic [ADDR:0]    issue_cnt;
    logic [ADDR:0]    recv_cnt;
    logic             inflight;
    logic             zdone_r;

    logic [WIDTH-1:0] fifo_mem [0:2];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic [1:0]       fifo_cnt;

    logic issue;
    logic accept;
    logic drain_ok;
    logic push;
    logic pop;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit counts words already queued plus the one still in the BRAM pipe,
    // so the issue decision never looks at out_ready.
    assign issue    = (state == S_RUN) && (issue_cnt < len_r) &&
                      (({1'b0, fifo_cnt} + {2'b00, inflight}) < 3'd3);
    assign drain_ok = (state == S_DRAIN) && (recv_cnt == len_r) &&
                      (fifo_cnt == 2'd0) && !inflight;
    assign accept   = (state == S_IDLE) && !zdone_r && start;
    assign push     = inflight;
    assign pop      = out_valid && out_ready;

    assign mem_en    = issue;
    assign mem_we    = 1'b0;
    assign mem_addr  = base_r + issue_cnt[ADDR-1:0];
    assign busy      = (state != S_IDLE) && !drain_ok;
    assign done      = drain_ok || zdone_r;
    assign out_valid = (fifo_cnt != 2'd0);
    assign out_data  = fifo_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            base_r    <= '0;
            len_r     <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            inflight  <= 1'b0;
            zdone_r   <= 1'b0;
        end else begin
            inflight <= issue;
            zdone_r  <= accept && (len == '0);
            if (inflight)
                recv_cnt <= recv_cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    if (accept && (len != '0)) begin
                        base_r    <= base;
                        len_r     <= len;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (issue)
                        issue_cnt <= issue_cnt + 1'b1;
                    if (issue_cnt == len_r)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (drain_ok)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 3; i++)
                fifo_mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= mem_dout;
                wr_ptr           <= ptr_next(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule
